ik_swift_ctrl: RTL and testbench

Host-side sequencer and register file for the IK solver. It accepts 32-bit register writes from the host bus and holds the target pose, the initial DH parameters and the joint types. On start it resets the solver, loads the DH parameters and runs 250-cycle solver iterations. After each iteration it checks the returned joint deltas against a tolerance, and it stops on convergence, on reaching the iteration limit, or on host abort. It sits between the bus slave port and the solver core and drives the solver's `en`, `rst` and input operands.

---
 rtl/ik_swift_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_ik_swift_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ik_swift_ctrl.sv
// rtl/ik_swift_ctrl.sv - host sequencer and register file for the IK solver
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   chipselect, write,   bus slave port; 8-bit word address, 32-bit data,
//   read, address,       readdata registered one cycle after a read strobe
//   writedata, readdata
//   irq                  level interrupt while done and not yet cleared
//   solver_en/rst        solver enable and reset pulse
//   dh_load              one-cycle pulse to copy dh_param_init into the solver
//   dh_param_init        initial DH parameters [joint][THETA,L_OFF,L_DIST,ALPHA]
//   target               target pose x, y, z, i, j, k
//   joint_type           1 = rotational, 0 = translational
//   delta                per-joint update from the solver, sampled at frame end
//   dh_param_cur         current solver DH parameters for readback
module ik_swift_ctrl #(
  parameter int unsigned FRAME        = 250,
  parameter int unsigned ITER_DEFAULT = 100,
  parameter logic [31:0] TOL_DEFAULT  = 32'h0000_0100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   chipselect,
  input  logic                   write,
  input  logic                   read,
  input  logic [7:0]             address,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  output logic                   irq,
  output logic                   solver_en,
  output logic                   solver_rst,
  output logic                   dh_load,
  output logic [5:0][3:0][35:0]  dh_param_init,
  output logic [5:0][35:0]       target,
  output logic [5:0]             joint_type,
  input  logic [5:0][35:0]       delta,
  input  logic [5:0][3:0][35:0]  dh_param_cur
);

  localparam int FW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_next;

  logic [7:0]    max_iter;
  logic [31:0]   tol;
  logic [FW-1:0] frame_cnt;
  logic [7:0]    iter_cnt;
  logic          done_flag, conv_flag, abort_flag, irq_flag;

  logic          wr_en, rd_en, ctrl_wr, busy;
  logic          start_go, abort_go, irq_clr;
  logic          frame_end, converged, limit_hit;
  logic [7:0]    eff_max;
  logic [4:0]    dh_pair;
  logic [2:0]    dh_j;
  logic [1:0]    dh_p;
  logic          in_tgt, in_dh, in_del, in_cur;
  logic [31:0]   rd_val;

  assign wr_en   = chipselect && write;
  assign rd_en   = chipselect && read;
  assign ctrl_wr = wr_en && (address == 8'h00);
  assign busy    = (state == LOAD) || (state == RUN);

  // Start with abort in the same write: abort wins when busy, and when not
  // busy the pair cancels out entirely.
  assign start_go = ctrl_wr && writedata[0] && !writedata[1] && !busy;
  assign abort_go = ctrl_wr && writedata[1] && busy;
  assign irq_clr  = ctrl_wr && writedata[2];

  // Address decode. Both DH windows (0x20 and 0x60) map to the same
  // joint/param pair via address[5:1] - 0x10 modulo 32.
  assign in_tgt  = (address >= 8'h10) && (address <= 8'h1B);
  assign in_dh   = (address >= 8'h20) && (address <= 8'h4F);
  assign in_del  = (address >= 8'h50) && (address <= 8'h5B);
  assign in_cur  = (address >= 8'h60) && (address <= 8'h8F);
  assign dh_pair = address[5:1] - 5'h10;
  assign dh_j    = dh_pair[4:2];
  assign dh_p    = dh_pair[1:0];

  // |x| with -2^35 saturating to 2^35-1.
  function automatic logic [35:0] abs36(input logic [35:0] v);
    if (!v[35])                   return v;
    else if (v == {1'b1, 35'b0})  return {1'b0, {35{1'b1}}};
    else                          return -v;
  endfunction

  function automatic logic [31:0] word_sel(input logic [35:0] v, input logic hi);
    return hi ? {{28{v[35]}}, v[35:32]} : v[31:0];
  endfunction

  always_comb begin
    converged = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (abs36(delta[j]) > {4'b0, tol}) converged = 1'b0;
    end
  end

  assign eff_max   = (max_iter == 8'd0) ? 8'd1 : max_iter;
  assign limit_hit = ({1'b0, iter_cnt} + 9'd1) >= {1'b0, eff_max};
  assign frame_end = (state == RUN) && (frame_cnt == FRAME_LAST);

  // Host-writable registers; locked while a solve is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_iter      <= 8'(ITER_DEFAULT);
      tol           <= TOL_DEFAULT;
      joint_type    <= '0;
      target        <= '0;
      dh_param_init <= '0;
    end else if (wr_en && !busy) begin
      if (address == 8'h02) begin
        max_iter <= writedata[7:0];
      end else if (address == 8'h03) begin
        tol <= writedata;
      end else if (address == 8'h04) begin
        joint_type <= writedata[5:0];
      end else if (in_tgt) begin
        if (address[0]) target[address[3:1]][35:32] <= writedata[3:0];
        else            target[address[3:1]][31:0]  <= writedata;
      end else if (in_dh) begin
        if (address[0]) dh_param_init[dh_j][dh_p][35:32] <= writedata[3:0];
        else            dh_param_init[dh_j][dh_p][31:0]  <= writedata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    solver_en  = 1'b0;
    solver_rst = 1'b0;
    dh_load    = 1'b0;
    case (state)
      IDLE: begin
        if (start_go) state_next = LOAD;
      end
      LOAD: begin
        solver_rst = 1'b1;
        dh_load    = 1'b1;
        state_next = abort_go ? DONE : RUN;
      end
      RUN: begin
        solver_en = 1'b1;
        if (abort_go)                                     state_next = DONE;
        else if (frame_end && (converged || limit_hit))   state_next = DONE;
      end
      DONE: begin
        if (start_go) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters and status flags. Clearing happens on the edge that enters
  // LOAD so STATUS already reads clean during the LOAD cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt  <= '0;
      iter_cnt   <= '0;
      done_flag  <= 1'b0;
      conv_flag  <= 1'b0;
      abort_flag <= 1'b0;
      irq_flag   <= 1'b0;
    end else begin
      if (irq_clr) irq_flag <= 1'b0;
      if (start_go) begin
        frame_cnt  <= '0;
        iter_cnt   <= '0;
        done_flag  <= 1'b0;
        conv_flag  <= 1'b0;
        abort_flag <= 1'b0;
        irq_flag   <= 1'b0;
      end else if (abort_go) begin
        done_flag  <= 1'b1;
        abort_flag <= 1'b1;
        irq_flag   <= 1'b1;
      end else if (state == RUN) begin
        if (frame_end) begin
          frame_cnt <= '0;
          iter_cnt  <= iter_cnt + 8'd1;
          if (converged || limit_hit) begin
            done_flag <= 1'b1;
            conv_flag <= converged;
            irq_flag  <= 1'b1;
          end
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  assign irq = irq_flag;

  always_comb begin
    rd_val = '0;
    if (address == 8'h01)
      rd_val = {16'b0, iter_cnt, 4'b0, abort_flag, conv_flag, done_flag, busy};
    else if (address == 8'h02) rd_val = {24'b0, max_iter};
    else if (address == 8'h03) rd_val = tol;
    else if (address == 8'h04) rd_val = {26'b0, joint_type};
    else if (in_tgt)           rd_val = word_sel(target[address[3:1]], address[0]);
    else if (in_dh)            rd_val = word_sel(dh_param_init[dh_j][dh_p], address[0]);
    else if (in_del)           rd_val = word_sel(delta[address[3:1]], address[0]);
    else if (in_cur)           rd_val = word_sel(dh_param_cur[dh_j][dh_p], address[0]);
  end

  always_ff @(posedge clk) begin
    if (rst)        readdata <= '0;
    else if (rd_en) readdata <= rd_val;
  end

endmodule

// File: tb/tb_ik_swift_ctrl.sv
// tb/tb_ik_swift_ctrl.sv - scoreboard testbench for ik_swift_ctrl
module tb_ik_swift_ctrl;
  localparam int FRAME = 250;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  chipselect, write, read;
  logic [7:0]            address;
  logic [31:0]           writedata, readdata;
  logic                  irq, solver_en, solver_rst, dh_load;
  logic [5:0][3:0][35:0] dh_param_init, dh_param_cur;
  logic [5:0][35:0]      target, delta;
  logic [5:0]            joint_type;

  int checks = 0;
  int errors = 0;

  string       exp_name[$];
  logic [31:0] exp_val[$];
  string       mon_name;
  logic [31:0] mon_exp;
  logic        rd_pend = 1'b0;

  int k, rst_seen;

  ik_swift_ctrl #(.FRAME(FRAME), .ITER_DEFAULT(100), .TOL_DEFAULT(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata), .irq(irq),
    .solver_en(solver_en), .solver_rst(solver_rst), .dh_load(dh_load),
    .dh_param_init(dh_param_init), .target(target), .joint_type(joint_type),
    .delta(delta), .dh_param_cur(dh_param_cur)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: a read strobe seen at a rising edge means readdata is valid at
  // the following falling edge; pop the oldest expectation and compare.
  always @(posedge clk) rd_pend <= chipselect && read && !rst;

  always @(negedge clk) begin
    if (rd_pend) begin
      checks++;
      if (exp_val.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got %0h expected no read", readdata);
      end else begin
        mon_name = exp_name.pop_front();
        mon_exp  = exp_val.pop_front();
        if (readdata !== mon_exp) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h", mon_name, readdata, mon_exp);
        end
      end
    end
  end

  // Tasks are entered just after a falling edge and return at the next one.
  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, input logic [31:0] e, input string nm);
    exp_name.push_back(nm);
    exp_val.push_back(e);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
  endtask

  // Called at the falling edge inside LOAD (n = 0). Counts falling edges
  // until solver_en drops, optionally changing delta and injecting one bus
  // write along the way.
  task automatic run_len(input int chg_at, input logic [35:0] chg_val,
                         input int inj_at, input logic [7:0] inj_a, input logic [31:0] inj_d,
                         output int n, output int rst_n);
    n = 0;
    rst_n = 0;
    do begin
      if (inj_at > 0 && n == inj_at) begin
        chipselect = 1'b1; write = 1'b1; address = inj_a; writedata = inj_d;
      end else begin
        chipselect = 1'b0; write = 1'b0;
      end
      if (chg_at > 0 && n == chg_at) delta = {6{chg_val}};
      @(negedge clk);
      n++;
      if (solver_rst) rst_n++;
    end while (solver_en === 1'b1 && n < 4 * FRAME);
    chipselect = 1'b0; write = 1'b0;
  endtask

  initial begin
    rst = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0; delta = '0; dh_param_cur = '0;
    dh_param_cur[5][3] = 36'h7_89AB_CDEF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_readdata", readdata, 0);
    check("rst_solver_en", solver_en, 0);
    check("rst_irq", irq, 0);
    check("rst_solver_rst", solver_rst, 0);
    check("rst_dh_load", dh_load, 0);
    bus_rd(8'h02, 32'd100, "rst_max_iter");
    bus_rd(8'h03, 32'h100, "rst_tol");
    bus_rd(8'h01, 32'h0, "rst_status");

    // Register access
    bus_wr(8'h25, 32'hF);
    bus_rd(8'h25, 32'hFFFF_FFFF, "dh02_hi_signext");
    check("dh02_port", dh_param_init[0][2], 36'hF_0000_0000);
    bus_wr(8'h11, 32'h3);
    bus_rd(8'h11, 32'h0000_0003, "tgt0_hi");
    bus_wr(8'h10, 32'h1234_5678);
    bus_rd(8'h10, 32'h1234_5678, "tgt0_lo");
    check("tgt0_port", target[0], 36'h3_1234_5678);
    bus_wr(8'h04, 32'hFFFF_FF2A);
    bus_rd(8'h04, 32'h2A, "joint_type");
    check("joint_type_port", joint_type, 6'h2A);
    bus_wr(8'h9F, 32'hCAFE_F00D);
    bus_rd(8'h9F, 32'h0, "unmapped_read");
    bus_rd(8'h00, 32'h0, "ctrl_read");
    bus_rd(8'h8E, 32'h89AB_CDEF, "cur53_lo");
    bus_rd(8'h8F, 32'h7, "cur53_hi");

    // Convergence at iteration 3
    bus_wr(8'h02, 32'd10);
    bus_wr(8'h03, 32'h100);
    delta = {6{36'h0_0000_1000}};
    bus_wr(8'h00, 32'h1);
    check("conv_load_rst", solver_rst, 1);
    check("conv_load_dh", dh_load, 1);
    check("conv_load_en", solver_en, 0);
    run_len(2 * FRAME + 1, 36'h0_0000_00FF, 0, 8'h00, 32'h0, k, rst_seen);
    check("conv_len", k, 3 * FRAME + 1);
    check("conv_irq", irq, 1);
    bus_rd(8'h01, 32'h0000_0306, "conv_status");

    // Iteration limit with a saturating -2^35 delta; busy write locked out
    bus_wr(8'h02, 32'd2);
    delta = '0;
    delta[5] = 36'h8_0000_0000;
    bus_wr(8'h00, 32'h1);
    check("lim_irq_cleared", irq, 0);
    run_len(0, 36'h0, 10, 8'h10, 32'hDEAD_BEEF, k, rst_seen);
    check("lim_len", k, 2 * FRAME + 1);
    bus_rd(8'h01, 32'h0000_0202, "lim_status");
    bus_rd(8'h10, 32'h1234_5678, "busy_write_ignored");
    bus_rd(8'h5B, 32'hFFFF_FFF8, "delta5_hi");
    bus_rd(8'h5A, 32'h0, "delta5_lo");
    bus_wr(8'h00, 32'h4);
    check("irq_clear", irq, 0);
    bus_rd(8'h01, 32'h0000_0202, "irq_clear_keeps_done");

    // Abort at frame cycle 100 of iteration 1
    bus_wr(8'h02, 32'd10);
    delta = {6{36'h0_0000_1000}};
    bus_wr(8'h00, 32'h1);
    repeat (101) @(negedge clk);
    check("abort_pre_en", solver_en, 1);
    bus_wr(8'h00, 32'h2);
    check("abort_en", solver_en, 0);
    check("abort_irq", irq, 1);
    bus_rd(8'h01, 32'h0000_000A, "abort_status");
    bus_wr(8'h00, 32'h1);
    check("restart_rst", solver_rst, 1);
    check("restart_dh", dh_load, 1);
    @(negedge clk);
    check("restart_rst_pulse", solver_rst, 0);
    check("restart_dh_pulse", dh_load, 0);
    bus_rd(8'h01, 32'h0000_0001, "restart_status");
    bus_wr(8'h00, 32'h2);
    bus_rd(8'h01, 32'h0000_000A, "abort2_status");

    // Start+abort while not busy does nothing
    bus_wr(8'h00, 32'h3);
    check("start_abort_idle_rst", solver_rst, 0);
    bus_rd(8'h01, 32'h0000_000A, "start_abort_idle_status");

    // Start while running is ignored; MAX_ITER=0 acts as 1
    bus_wr(8'h02, 32'd0);
    bus_wr(8'h00, 32'h1);
    run_len(0, 36'h0, 50, 8'h00, 32'h1, k, rst_seen);
    check("restart_ignored_len", k, FRAME + 1);
    check("restart_ignored_rst", rst_seen, 0);
    bus_rd(8'h01, 32'h0000_0102, "max0_status");

    repeat (3) @(negedge clk);
    checks++;
    if (exp_val.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0", exp_val.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
